// File: rtl/siw_addrgen.sv
// Two-level (period x iterations) address generator for one BRAM port.
// Optional macro SIW_ADDRGEN_PAUSE_EN adds a pause input that freezes DELAY/RUN.
module siw_addrgen #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10,
  parameter int DLY_W  = 4
) (
  input  logic              siw_addrgen_clk,
  input  logic              siw_addrgen_rst_n,
  input  logic              siw_addrgen_init,
  input  logic              siw_addrgen_run,
  input  logic [ADDR_W-1:0] siw_addrgen_start,
  input  logic [ADDR_W-1:0] siw_addrgen_incr,
  input  logic [ADDR_W-1:0] siw_addrgen_shift,
  input  logic [CNT_W-1:0]  siw_addrgen_period,
  input  logic [CNT_W-1:0]  siw_addrgen_iterations,
  input  logic [DLY_W-1:0]  siw_addrgen_delay,
  input  logic              siw_addrgen_rnw,
`ifdef SIW_ADDRGEN_PAUSE_EN
  input  logic              siw_addrgen_pause,
`endif
  output logic [ADDR_W-1:0] siw_addrgen_address,
  output logic              siw_addrgen_enable,
  output logic              siw_addrgen_write_en,
  output logic              siw_addrgen_busy,
  output logic              siw_addrgen_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_r, state_s;

  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [CNT_W-1:0]  elem_r, elem_s;
  logic [CNT_W-1:0]  iter_r, iter_s;
  logic [DLY_W-1:0]  dly_r, dly_s;

  logic [ADDR_W-1:0] start_r, incr_r, shift_r;
  logic [CNT_W-1:0]  period_r, iters_r;
  logic [DLY_W-1:0]  delay_r;
  logic              rnw_r, rnw_s;

  logic enable_r, enable_s;
  logic write_en_r, write_en_s;
  logic busy_r, busy_s;
  logic done_r, done_s;

  logic load_s;
  logic hold_s;
  logic pause_s;
  logic elem_last_s;
  logic iter_last_s;

`ifdef SIW_ADDRGEN_PAUSE_EN
  assign pause_s = siw_addrgen_pause;
`else
  assign pause_s = 1'b0;
`endif

  assign elem_last_s = (elem_r == (period_r - CNT_W'(1)));
  assign iter_last_s = (iter_r == (iters_r - CNT_W'(1)));

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge siw_addrgen_clk or negedge siw_addrgen_rst_n) begin
    if (!siw_addrgen_rst_n) begin
      state_r    <= IDLE;
      addr_r     <= {ADDR_W{1'b0}};
      elem_r     <= {CNT_W{1'b0}};
      iter_r     <= {CNT_W{1'b0}};
      dly_r      <= {DLY_W{1'b0}};
      start_r    <= {ADDR_W{1'b0}};
      incr_r     <= {ADDR_W{1'b0}};
      shift_r    <= {ADDR_W{1'b0}};
      period_r   <= {CNT_W{1'b0}};
      iters_r    <= {CNT_W{1'b0}};
      delay_r    <= {DLY_W{1'b0}};
      rnw_r      <= 1'b0;
      enable_r   <= 1'b0;
      write_en_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      elem_r     <= elem_s;
      iter_r     <= iter_s;
      dly_r      <= dly_s;
      enable_r   <= enable_s;
      write_en_r <= write_en_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      if (load_s) begin
        start_r  <= siw_addrgen_start;
        incr_r   <= siw_addrgen_incr;
        shift_r  <= siw_addrgen_shift;
        period_r <= siw_addrgen_period;
        iters_r  <= siw_addrgen_iterations;
        delay_r  <= siw_addrgen_delay;
        rnw_r    <= siw_addrgen_rnw;
      end
    end
  end

  // Next state, address and counters; init overrides everything.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    elem_s  = elem_r;
    iter_s  = iter_r;
    dly_s   = dly_r;
    load_s  = 1'b0;
    hold_s  = 1'b0;
    if (siw_addrgen_init) begin
      state_s = IDLE;
      addr_s  = {ADDR_W{1'b0}};
      elem_s  = {CNT_W{1'b0}};
      iter_s  = {CNT_W{1'b0}};
      dly_s   = {DLY_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (siw_addrgen_run) begin
            load_s = 1'b1;
            if ((siw_addrgen_period == {CNT_W{1'b0}}) ||
                (siw_addrgen_iterations == {CNT_W{1'b0}})) begin
              state_s = DONE;
            end else if (siw_addrgen_delay != {DLY_W{1'b0}}) begin
              state_s = DELAY;
              dly_s   = siw_addrgen_delay;
            end else begin
              state_s = RUN;
              addr_s  = siw_addrgen_start;
              elem_s  = {CNT_W{1'b0}};
              iter_s  = {CNT_W{1'b0}};
            end
          end else begin
            state_s = IDLE;
          end
        end
        DELAY: begin
          if (pause_s) begin
            hold_s = 1'b1;
          end else if (dly_r == DLY_W'(1)) begin
            state_s = RUN;
            addr_s  = start_r;
            elem_s  = {CNT_W{1'b0}};
            iter_s  = {CNT_W{1'b0}};
          end else begin
            dly_s = dly_r - DLY_W'(1);
          end
        end
        RUN: begin
          // addr_r has already been presented; a pause only defers the step.
          if (pause_s) begin
            hold_s = 1'b1;
          end else if (elem_last_s && iter_last_s) begin
            state_s = DONE;
          end else if (elem_last_s) begin
            addr_s = addr_r + shift_r;
            elem_s = {CNT_W{1'b0}};
            iter_s = iter_r + CNT_W'(1);
          end else begin
            addr_s = addr_r + incr_r;
            elem_s = elem_r + CNT_W'(1);
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Output values for the next cycle, derived from the next state.
  always_comb begin
    enable_s   = 1'b0;
    write_en_s = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    if (load_s) begin
      rnw_s = siw_addrgen_rnw;
    end else begin
      rnw_s = rnw_r;
    end
    case (state_s)
      RUN: begin
        busy_s = 1'b1;
        if (hold_s) begin
          enable_s = 1'b0;
        end else begin
          enable_s = 1'b1;
        end
        write_en_s = enable_s & ~rnw_s;
      end
      DELAY: begin
        busy_s = 1'b1;
      end
      DONE: begin
        done_s = 1'b1;
      end
      IDLE: begin
        busy_s = 1'b0;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign siw_addrgen_address  = addr_r;
  assign siw_addrgen_enable   = enable_r;
  assign siw_addrgen_write_en = write_en_r;
  assign siw_addrgen_busy     = busy_r;
  assign siw_addrgen_done     = done_r;

endmodule

// File: tb/tb_siw_addrgen.sv
// Scoreboard bench for siw_addrgen: expected per-cycle outputs are queued when
// a run is launched and compared cycle by cycle on the falling edge.
module tb_siw_addrgen;

  logic       clk;
  logic       rst_n;
  logic       init;
  logic       run;
  logic [9:0] start;
  logic [9:0] incr;
  logic [9:0] shift;
  logic [9:0] period;
  logic [9:0] iterations;
  logic [3:0] delay;
  logic       rnw;
`ifdef SIW_ADDRGEN_PAUSE_EN
  logic       pause;
`endif
  logic [9:0] address;
  logic       enable;
  logic       write_en;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic       en;
    logic       we;
    logic [9:0] addr;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  logic [9:0] prev_addr;

  siw_addrgen #(.ADDR_W(10), .CNT_W(10), .DLY_W(4)) dut (
    .siw_addrgen_clk        (clk),
    .siw_addrgen_rst_n      (rst_n),
    .siw_addrgen_init       (init),
    .siw_addrgen_run        (run),
    .siw_addrgen_start      (start),
    .siw_addrgen_incr       (incr),
    .siw_addrgen_shift      (shift),
    .siw_addrgen_period     (period),
    .siw_addrgen_iterations (iterations),
    .siw_addrgen_delay      (delay),
    .siw_addrgen_rnw        (rnw),
`ifdef SIW_ADDRGEN_PAUSE_EN
    .siw_addrgen_pause      (pause),
`endif
    .siw_addrgen_address    (address),
    .siw_addrgen_enable     (enable),
    .siw_addrgen_write_en   (write_en),
    .siw_addrgen_busy       (busy),
    .siw_addrgen_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, want);
    end
  endtask

  task automatic sb_push(input logic en, input logic we, input logic [9:0] addr,
                         input logic bz, input logic dn);
    exp_t e;
    e.en = en; e.we = we; e.addr = addr; e.busy = bz; e.done = dn;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t e;
    e = sb_q.pop_front();
    check_val("enable", {31'd0, enable}, {31'd0, e.en});
    check_val("write_en", {31'd0, write_en}, {31'd0, e.we});
    check_val("address", {22'd0, address}, {22'd0, e.addr});
    check_val("busy", {31'd0, busy}, {31'd0, e.busy});
    check_val("done", {31'd0, done}, {31'd0, e.done});
  endtask

  task automatic scramble_cfg();
    start      = 10'($urandom);
    incr       = 10'($urandom);
    shift      = 10'($urandom);
    period     = 10'($urandom);
    iterations = 10'($urandom);
    delay      = 4'($urandom);
    rnw        = 1'($urandom);
  endtask

  // Launch a run and check every cycle until the expected trace is consumed.
  // rerun > 0 raises run again during that cycle; it must be ignored.
  task automatic run_seq(input logic [9:0] st, input logic [9:0] inc, input logic [9:0] sh,
                         input logic [9:0] per, input logic [9:0] it, input logic [3:0] dl,
                         input logic rw, input int rerun);
    logic [9:0] a;
    logic [9:0] last;
    int         k;
    start = st; incr = inc; shift = sh; period = per; iterations = it;
    delay = dl; rnw = rw; run = 1'b1;
    last = prev_addr;
    if (per == 10'd0 || it == 10'd0) begin
      sb_push(1'b0, 1'b0, prev_addr, 1'b0, 1'b1);
    end else begin
      for (int c = 0; c < int'(dl); c++) sb_push(1'b0, 1'b0, prev_addr, 1'b1, 1'b0);
      a = st;
      for (int i = 0; i < int'(it); i++) begin
        for (int e = 0; e < int'(per); e++) begin
          sb_push(1'b1, ~rw, a, 1'b1, 1'b0);
          last = a;
          a = (e == int'(per) - 1) ? a + sh : a + inc;
        end
      end
      sb_push(1'b0, 1'b0, last, 1'b0, 1'b1);
    end
    sb_push(1'b0, 1'b0, last, 1'b0, 1'b0);
    prev_addr = last;
    k = 1;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      sb_compare();
      run = (k == rerun);
      scramble_cfg();
      k++;
    end
    run = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; init = 1'b0; run = 1'b0;
    start = 10'd0; incr = 10'd0; shift = 10'd0; period = 10'd0;
    iterations = 10'd0; delay = 4'd0; rnw = 1'b0;
`ifdef SIW_ADDRGEN_PAUSE_EN
    pause = 1'b0;
`endif
    prev_addr = 10'd0;
    @(negedge clk);
    @(negedge clk);
    sb_push(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    sb_compare();
    rst_n = 1'b1;
    @(negedge clk);

    // Two periods of three reads with a shift between them.
    run_seq(10'h010, 10'd1, 10'd6, 10'd3, 10'd2, 4'd0, 1'b1, 0);
    // Writes wrapping through the top of the address space.
    run_seq(10'h3FE, 10'd1, 10'd5, 10'd4, 10'd1, 4'd0, 1'b0, 0);
    // Start delay of three, with an ignored run while busy.
    run_seq(10'h120, 10'd4, 10'd0, 10'd2, 10'd1, 4'd3, 1'b1, 2);
    // Zero-length sequence, with an ignored run during DONE.
    run_seq(10'h055, 10'd1, 10'd1, 10'd0, 10'd3, 4'd2, 1'b0, 1);
    run_seq(10'h055, 10'd1, 10'd1, 10'd3, 10'd0, 4'd0, 1'b1, 0);
    // Negative steps and a wrapping shift.
    run_seq(10'h005, 10'h3FF, 10'h3F0, 10'd2, 10'd3, 4'd1, 1'b0, 0);

    // init during a ten-access run aborts it without a done pulse.
    start = 10'h100; incr = 10'd3; shift = 10'd1; period = 10'd5;
    iterations = 10'd2; delay = 4'd0; rnw = 1'b1; run = 1'b1;
    sb_push(1'b1, 1'b0, 10'h100, 1'b1, 1'b0);
    sb_push(1'b1, 1'b0, 10'h103, 1'b1, 1'b0);
    sb_push(1'b1, 1'b0, 10'h106, 1'b1, 1'b0);
    sb_push(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    sb_push(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      sb_compare();
      run = 1'b0;
      init = (k == 3);
    end
    init = 1'b0;
    prev_addr = 10'd0;
    run_seq(10'h2A0, 10'd2, 10'd8, 10'd2, 10'd2, 4'd0, 1'b0, 0);

    // Asynchronous reset in the middle of a sequence.
    start = 10'h050; incr = 10'd1; shift = 10'd1; period = 10'd8;
    iterations = 10'd1; delay = 4'd0; rnw = 1'b0; run = 1'b1;
    sb_push(1'b1, 1'b1, 10'h050, 1'b1, 1'b0);
    sb_push(1'b1, 1'b1, 10'h051, 1'b1, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      sb_compare();
      run = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    sb_push(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    sb_compare();
    @(negedge clk);
    rst_n = 1'b1;
    sb_push(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    sb_push(1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    while (sb_q.size() > 0) begin
      @(negedge clk);
      sb_compare();
    end
    prev_addr = 10'd0;

`ifdef SIW_ADDRGEN_PAUSE_EN
    // Pause high during cycles 3-4 of a five-access run.
    start = 10'd0; incr = 10'd2; shift = 10'd2; period = 10'd5;
    iterations = 10'd1; delay = 4'd0; rnw = 1'b1; run = 1'b1;
    sb_push(1'b1, 1'b0, 10'd0, 1'b1, 1'b0);
    sb_push(1'b1, 1'b0, 10'd2, 1'b1, 1'b0);
    sb_push(1'b1, 1'b0, 10'd4, 1'b1, 1'b0);
    sb_push(1'b0, 1'b0, 10'd4, 1'b1, 1'b0);
    sb_push(1'b0, 1'b0, 10'd4, 1'b1, 1'b0);
    sb_push(1'b1, 1'b0, 10'd6, 1'b1, 1'b0);
    sb_push(1'b1, 1'b0, 10'd8, 1'b1, 1'b0);
    sb_push(1'b0, 1'b0, 10'd8, 1'b0, 1'b1);
    sb_push(1'b0, 1'b0, 10'd8, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      sb_compare();
      run = 1'b0;
      pause = (k == 3 || k == 4);
    end
    pause = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
